ap_handshake_profiler: RTL and testbench
========================================

Name: ap_handshake_profiler

Overview:
- Synthesizable, parametrised successor to the simulation-only HLS module-status monitors.
- Observes ap_start/ap_ready/ap_done/ap_continue of NUM_CH HLS blocks (e.g. des_encrypt top, generate_subkeys, des_core) in-circuit.
- Keeps per-channel transaction, busy, stall and latency statistics.
- Exposes the statistics through a registered read port, so profiling works on FPGA without CSV dumps.

Parameters:
- NUM_CH, 3, number of monitored handshake channels (1..16).
- CNT_W, 32, width of event/cycle counters and of rd_data.
- LAT_W, 16, width of latency registers (LAT_W <= CNT_W).

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- finish  in  1  end-of-run; first high cycle freezes all statistics.
- ap_start  in  NUM_CH  per-channel ap_start.
- ap_ready  in  NUM_CH  per-channel ap_ready.
- ap_done  in  NUM_CH  per-channel ap_done.
- ap_continue  in  NUM_CH  per-channel ap_continue; tie 1 for blocks without it.
- clear  in  1  synchronous clear of statistics and overflow flags.
- rd_en  in  1  read request.
- rd_ch  in  4  channel index.
- rd_sel  in  3  statistic select.
- rd_valid  out  1  read data valid, one cycle after rd_en.
- rd_data  out  CNT_W  read data, zero-extended.
- frozen  out  1  statistics frozen by finish.
- overflow  out  NUM_CH  sticky per-channel saturation flag.

Behaviour:
- Reset: all counters 0, lat_max 0, lat_min all-ones (if enabled), all channel FSMs IDLE. Outputs rd_valid=0, rd_data=0, frozen=0, overflow=0.
- Per-channel FSM, 2-bit state code:
  - IDLE(0): goes to BUSY when ap_start=1. Latency counter loads 1 in that cycle.
  - BUSY(1): latency counter increments each cycle and saturates at 2^LAT_W-1.
    - ap_done&ap_continue ends the transaction. Next state is IDLE, or BUSY with latency reloaded to 1 if ap_start is high the same cycle (back-to-back).
    - ap_done&!ap_continue goes to DONE_WAIT; the latency value is captured.
  - DONE_WAIT(2): stall_cycles increments each cycle. Leaves on ap_continue=1 under the same rules as BUSY completion.
- Counters (per channel, CNT_W bits):
  - start_cnt: +1 per cycle with ap_start&ap_ready.
  - done_cnt: +1 per cycle with ap_done&ap_continue.
  - busy_cycles: +1 per cycle in BUSY.
  - stall_cycles: +1 per cycle in DONE_WAIT.
- Latency: on transaction completion, lat_last is set to the latency counter value (start cycle through done cycle inclusive), and lat_max = max(lat_max, lat_last).
- Overlapped starts (pipelined block, start_cnt>done_cnt+1): latency tracks the oldest transaction only. Counters remain exact.
- Saturation: any counter at all-ones holds its value and sets overflow[ch]. overflow clears only on reset or clear.
- finish:
  - The first cycle finish=1 sets frozen=1, sticky until reset.
  - While frozen, no counter, latency or FSM register changes. Events on that same cycle are not recorded.
  - The read port stays live.
- clear:
  - Zeroes counters, latencies and overflow, and forces FSMs to IDLE. frozen is unaffected.
  - clear wins over any simultaneous event; that cycle's events are dropped.
  - reset wins over clear.
- Read port:
  - rd_en sampled at cycle N gives rd_valid=1 and rd_data at N+1. Back-to-back reads are allowed every cycle.
  - rd_valid=0 gives rd_data=0.
  - rd_sel map: 0 start_cnt, 1 done_cnt, 2 busy_cycles, 3 stall_cycles, 4 lat_last, 5 lat_max, 6 lat_min, 7 {overflow[ch], state code}.
  - rd_ch>=NUM_CH returns 0 with rd_valid=1.
  - A read in the same cycle as an update returns the pre-update value.
- Reset mid-transaction discards all state; no partial latency is recorded.

Optional Feature:
- Macro: AP_PROFILER_MIN_LAT_EN.
- Defined: per-channel lat_min register, reset and clear value all-ones. On completion, lat_min = min(lat_min, lat_last). rd_sel=6 returns it.
- Undefined: no lat_min storage; rd_sel=6 returns 0.

Test Plan:
- Single transaction ch0: start 1 cycle with ready, done&continue 5 cycles later -> start_cnt=1, done_cnt=1, lat_last=6, lat_max=6, busy_cycles=6.
- Continue stall ch2: done held with ap_continue=0 for 4 cycles -> stall_cycles=4, state reads 2 during the stall, lat_last = latency at first done.
- Back-to-back ch1: done&continue and start in the same cycle, three transactions of latency 3,7,4 -> done_cnt=3, lat_max=7, lat_min=3 (MIN_LAT_EN defined) / 0 (undefined).
- Saturation: CNT_W=4, 17 starts -> start_cnt=15, overflow[ch]=1; clear -> 0, overflow=0.
- finish: assert finish mid-BUSY, then 10 further cycles of activity -> frozen=1, all reads unchanged from the finish cycle, reads still valid one cycle after rd_en.
- Clear/reset precedence: clear coincident with done -> done_cnt=0. reset coincident with clear and mid-BUSY -> all outputs at reset values next cycle; rd_ch=NUM_CH -> rd_data=0, rd_valid=1.

Source files
------------

// File: rtl/ap_handshake_profiler.sv
// In-circuit profiler for NUM_CH HLS ap_start/ap_ready/ap_done/ap_continue handshakes.
// Define AP_PROFILER_MIN_LAT_EN to add a per-channel minimum-latency register (rd_sel 6).
module ap_handshake_profiler #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 32,
  parameter int LAT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              finish,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [3:0]        rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              frozen,
  output logic [NUM_CH-1:0] overflow
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_DONE_WAIT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  state_e           state_q      [NUM_CH];
  state_e           state_d      [NUM_CH];
  logic [CNT_W-1:0] start_cnt_q  [NUM_CH];
  logic [CNT_W-1:0] start_cnt_d  [NUM_CH];
  logic [CNT_W-1:0] done_cnt_q   [NUM_CH];
  logic [CNT_W-1:0] done_cnt_d   [NUM_CH];
  logic [CNT_W-1:0] busy_cnt_q   [NUM_CH];
  logic [CNT_W-1:0] busy_cnt_d   [NUM_CH];
  logic [CNT_W-1:0] stall_cnt_q  [NUM_CH];
  logic [CNT_W-1:0] stall_cnt_d  [NUM_CH];
  logic [LAT_W-1:0] lat_cnt_q    [NUM_CH];
  logic [LAT_W-1:0] lat_cnt_d    [NUM_CH];
  logic [LAT_W-1:0] lat_last_q   [NUM_CH];
  logic [LAT_W-1:0] lat_last_d   [NUM_CH];
  logic [LAT_W-1:0] lat_max_q    [NUM_CH];
  logic [LAT_W-1:0] lat_max_d    [NUM_CH];
`ifdef AP_PROFILER_MIN_LAT_EN
  logic [LAT_W-1:0] lat_min_q    [NUM_CH];
  logic [LAT_W-1:0] lat_min_d    [NUM_CH];
`endif
  logic [NUM_CH-1:0] overflow_q, overflow_d;
  logic              frozen_q, frozen_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic              upd_en;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) return v + CNT_W'(1);
    return v;
  endfunction

  function automatic logic cnt_hit(input logic [CNT_W-1:0] v, input logic en);
    return en && (v == CNT_MAX);
  endfunction

  function automatic logic [LAT_W-1:0] lat_inc(input logic [LAT_W-1:0] v);
    if (v != LAT_MAX) return v + LAT_W'(1);
    return v;
  endfunction

  // The finish cycle itself is already excluded from the statistics.
  assign upd_en   = !frozen_q && !finish;
  assign frozen_d = frozen_q | finish;

  always_comb begin
    logic             start_ev, done_ev, busy_ev, stall_ev, complete;
    logic [LAT_W-1:0] lat_now, lat_done;
    overflow_d = overflow_q;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c]     = state_q[c];
      start_cnt_d[c] = start_cnt_q[c];
      done_cnt_d[c]  = done_cnt_q[c];
      busy_cnt_d[c]  = busy_cnt_q[c];
      stall_cnt_d[c] = stall_cnt_q[c];
      lat_cnt_d[c]   = lat_cnt_q[c];
      lat_last_d[c]  = lat_last_q[c];
      lat_max_d[c]   = lat_max_q[c];
`ifdef AP_PROFILER_MIN_LAT_EN
      lat_min_d[c]   = lat_min_q[c];
`endif
      start_ev = ap_start[c] & ap_ready[c];
      done_ev  = ap_done[c] & ap_continue[c];
      busy_ev  = 1'b0;
      stall_ev = 1'b0;
      complete = 1'b0;
      lat_now  = lat_inc(lat_cnt_q[c]);
      lat_done = lat_cnt_q[c];
      if (!upd_en) begin
        // frozen: hold everything, including against clear
      end else if (clear) begin
        state_d[c]     = ST_IDLE;
        start_cnt_d[c] = '0;
        done_cnt_d[c]  = '0;
        busy_cnt_d[c]  = '0;
        stall_cnt_d[c] = '0;
        lat_cnt_d[c]   = '0;
        lat_last_d[c]  = '0;
        lat_max_d[c]   = '0;
`ifdef AP_PROFILER_MIN_LAT_EN
        lat_min_d[c]   = '1;
`endif
        overflow_d[c]  = 1'b0;
      end else begin
        case (state_q[c])
          ST_IDLE: begin
            if (ap_start[c]) begin
              state_d[c]   = ST_BUSY;
              lat_cnt_d[c] = LAT_W'(1);
              busy_ev      = 1'b1;
            end
          end
          ST_BUSY: begin
            busy_ev      = 1'b1;
            lat_cnt_d[c] = lat_now;
            if (done_ev) begin
              complete = 1'b1;
              lat_done = lat_now;
              if (ap_start[c]) begin
                lat_cnt_d[c] = LAT_W'(1);
              end else begin
                state_d[c] = ST_IDLE;
              end
            end else if (ap_done[c]) begin
              state_d[c] = ST_DONE_WAIT;
            end
          end
          ST_DONE_WAIT: begin
            stall_ev = 1'b1;
            if (ap_continue[c]) begin
              complete = 1'b1;
              lat_done = lat_cnt_q[c];
              if (ap_start[c]) begin
                state_d[c]   = ST_BUSY;
                lat_cnt_d[c] = LAT_W'(1);
              end else begin
                state_d[c] = ST_IDLE;
              end
            end
          end
          default: state_d[c] = ST_IDLE;
        endcase
        start_cnt_d[c] = cnt_inc(start_cnt_q[c], start_ev);
        done_cnt_d[c]  = cnt_inc(done_cnt_q[c], done_ev);
        busy_cnt_d[c]  = cnt_inc(busy_cnt_q[c], busy_ev);
        stall_cnt_d[c] = cnt_inc(stall_cnt_q[c], stall_ev);
        overflow_d[c]  = overflow_q[c] | cnt_hit(start_cnt_q[c], start_ev)
                       | cnt_hit(done_cnt_q[c], done_ev) | cnt_hit(busy_cnt_q[c], busy_ev)
                       | cnt_hit(stall_cnt_q[c], stall_ev);
        if (complete) begin
          lat_last_d[c] = lat_done;
          lat_max_d[c]  = (lat_done > lat_max_q[c]) ? lat_done : lat_max_q[c];
`ifdef AP_PROFILER_MIN_LAT_EN
          lat_min_d[c]  = (lat_done < lat_min_q[c]) ? lat_done : lat_min_q[c];
`endif
        end
      end
    end
  end

  // Read mux works on the registered (pre-update) statistics.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = '0;
    if (rd_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rd_ch == 4'(c)) begin
          case (rd_sel)
            3'd0: rd_data_d = start_cnt_q[c];
            3'd1: rd_data_d = done_cnt_q[c];
            3'd2: rd_data_d = busy_cnt_q[c];
            3'd3: rd_data_d = stall_cnt_q[c];
            3'd4: rd_data_d = CNT_W'(lat_last_q[c]);
            3'd5: rd_data_d = CNT_W'(lat_max_q[c]);
`ifdef AP_PROFILER_MIN_LAT_EN
            3'd6: rd_data_d = CNT_W'(lat_min_q[c]);
`else
            3'd6: rd_data_d = '0;
`endif
            default: rd_data_d = CNT_W'({overflow_q[c], state_q[c]});
          endcase
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]     <= ST_IDLE;
        start_cnt_q[c] <= '0;
        done_cnt_q[c]  <= '0;
        busy_cnt_q[c]  <= '0;
        stall_cnt_q[c] <= '0;
        lat_cnt_q[c]   <= '0;
        lat_last_q[c]  <= '0;
        lat_max_q[c]   <= '0;
`ifdef AP_PROFILER_MIN_LAT_EN
        lat_min_q[c]   <= '1;
`endif
      end
      overflow_q <= '0;
      frozen_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]     <= state_d[c];
        start_cnt_q[c] <= start_cnt_d[c];
        done_cnt_q[c]  <= done_cnt_d[c];
        busy_cnt_q[c]  <= busy_cnt_d[c];
        stall_cnt_q[c] <= stall_cnt_d[c];
        lat_cnt_q[c]   <= lat_cnt_d[c];
        lat_last_q[c]  <= lat_last_d[c];
        lat_max_q[c]   <= lat_max_d[c];
`ifdef AP_PROFILER_MIN_LAT_EN
        lat_min_q[c]   <= lat_min_d[c];
`endif
      end
      overflow_q <= overflow_d;
      frozen_q   <= frozen_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign frozen   = frozen_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ap_handshake_profiler.sv
// Directed bench for ap_handshake_profiler: a default-width instance plus a CNT_W=4 instance for saturation.
module tb_ap_handshake_profiler;
  localparam int NUM_CH = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset, finish, clear, rd_en;
  logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue;
  logic [3:0]        rd_ch;
  logic [2:0]        rd_sel;
  logic              rd_valid, frozen;
  logic [31:0]       rd_data;
  logic [NUM_CH-1:0] overflow;
  logic              rd_valid_s, frozen_s;
  logic [3:0]        rd_data_s;
  logic [NUM_CH-1:0] overflow_s;

  int total = 0;
  int bad   = 0;

`ifdef AP_PROFILER_MIN_LAT_EN
  localparam logic [31:0] LMIN_RST = 32'h0000_FFFF;
  localparam logic [31:0] LMIN_B2B = 32'd3;
`else
  localparam logic [31:0] LMIN_RST = 32'd0;
  localparam logic [31:0] LMIN_B2B = 32'd0;
`endif

  ap_handshake_profiler #(.NUM_CH(NUM_CH), .CNT_W(32), .LAT_W(16)) u_dut (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .clear(clear), .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .frozen(frozen), .overflow(overflow)
  );

  ap_handshake_profiler #(.NUM_CH(NUM_CH), .CNT_W(4), .LAT_W(4)) u_sat (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .clear(clear), .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_valid(rd_valid_s), .rd_data(rd_data_s), .frozen(frozen_s), .overflow(overflow_s)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ap_start    = '0;
    ap_ready    = '0;
    ap_done     = '0;
    ap_continue = '1;
    finish      = 1'b0;
    clear       = 1'b0;
    rd_en       = 1'b0;
    rd_ch       = 4'd0;
    rd_sel      = 3'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic rd(input int ch, input int sel, output logic v, output logic [31:0] d,
                    output logic [3:0] ds);
    rd_en  = 1'b1;
    rd_ch  = 4'(ch);
    rd_sel = 3'(sel);
    tick();
    v  = rd_valid;
    d  = rd_data;
    ds = rd_data_s;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic v; logic [31:0] d; logic [3:0] ds;
    do_reset();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
    total++; if (frozen !== 1'b0) begin bad++; $display("FAIL reset_frozen got=%0b exp=0", frozen); end
    total++; if (overflow !== 3'b000) begin bad++; $display("FAIL reset_overflow got=%b exp=000", overflow); end
    rd(0, 6, v, d, ds);
    total++; if (d !== LMIN_RST) begin bad++; $display("FAIL reset_lat_min got=%0h exp=%0h", d, LMIN_RST); end
    rd(1, 7, v, d, ds);
    total++; if (v !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL reset_state v=%0b got=%0d exp=0", v, d); end
  endtask

  task automatic test_single();
    logic v; logic [31:0] d; logic [3:0] ds;
    do_reset();
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
    repeat (4) tick();
    ap_done[0] = 1'b1;
    tick();
    ap_done[0] = 1'b0;
    rd(0, 0, v, d, ds);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL single_start_cnt got=%0d exp=1", d); end
    rd(0, 1, v, d, ds);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL single_done_cnt got=%0d exp=1", d); end
    rd(0, 4, v, d, ds);
    total++; if (d !== 32'd6) begin bad++; $display("FAIL single_lat_last got=%0d exp=6", d); end
    rd(0, 5, v, d, ds);
    total++; if (d !== 32'd6) begin bad++; $display("FAIL single_lat_max got=%0d exp=6", d); end
    rd(0, 2, v, d, ds);
    total++; if (d !== 32'd6) begin bad++; $display("FAIL single_busy got=%0d exp=6", d); end
    rd(0, 7, v, d, ds);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL single_state_after got=%0d exp=0", d); end
  endtask

  task automatic test_stall();
    logic v; logic [31:0] d; logic [3:0] ds;
    do_reset();
    ap_start[2] = 1'b1; ap_ready[2] = 1'b1;
    tick();
    ap_start[2] = 1'b0; ap_ready[2] = 1'b0;
    repeat (2) tick();
    ap_done[2] = 1'b1; ap_continue[2] = 1'b0;
    tick();
    rd(2, 7, v, d, ds);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL stall_state got=%0d exp=2", d); end
    repeat (2) tick();
    ap_continue[2] = 1'b1;
    tick();
    ap_done[2] = 1'b0;
    rd(2, 3, v, d, ds);
    total++; if (d !== 32'd4) begin bad++; $display("FAIL stall_cycles got=%0d exp=4", d); end
    rd(2, 4, v, d, ds);
    total++; if (d !== 32'd4) begin bad++; $display("FAIL stall_lat_last got=%0d exp=4", d); end
    rd(2, 1, v, d, ds);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL stall_done_cnt got=%0d exp=1", d); end
    rd(2, 2, v, d, ds);
    total++; if (d !== 32'd4) begin bad++; $display("FAIL stall_busy got=%0d exp=4", d); end
  endtask

  task automatic test_back_to_back();
    logic v; logic [31:0] d; logic [3:0] ds;
    do_reset();
    ap_start[1] = 1'b1; ap_ready[1] = 1'b1;
    tick();
    ap_start[1] = 1'b0; ap_ready[1] = 1'b0;
    tick();
    ap_done[1] = 1'b1; ap_start[1] = 1'b1; ap_ready[1] = 1'b1;
    tick();
    ap_done[1] = 1'b0; ap_start[1] = 1'b0; ap_ready[1] = 1'b0;
    repeat (5) tick();
    ap_done[1] = 1'b1; ap_start[1] = 1'b1; ap_ready[1] = 1'b1;
    tick();
    ap_done[1] = 1'b0; ap_start[1] = 1'b0; ap_ready[1] = 1'b0;
    repeat (2) tick();
    ap_done[1] = 1'b1;
    tick();
    ap_done[1] = 1'b0;
    rd(1, 1, v, d, ds);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL b2b_done_cnt got=%0d exp=3", d); end
    rd(1, 0, v, d, ds);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL b2b_start_cnt got=%0d exp=3", d); end
    rd(1, 5, v, d, ds);
    total++; if (d !== 32'd7) begin bad++; $display("FAIL b2b_lat_max got=%0d exp=7", d); end
    rd(1, 4, v, d, ds);
    total++; if (d !== 32'd4) begin bad++; $display("FAIL b2b_lat_last got=%0d exp=4", d); end
    rd(1, 6, v, d, ds);
    total++; if (d !== LMIN_B2B) begin bad++; $display("FAIL b2b_lat_min got=%0d exp=%0d", d, LMIN_B2B); end
    rd(1, 2, v, d, ds);
    total++; if (d !== 32'd12) begin bad++; $display("FAIL b2b_busy got=%0d exp=12", d); end
  endtask

  task automatic test_saturation();
    logic v; logic [31:0] d; logic [3:0] ds;
    do_reset();
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
    repeat (17) tick();
    ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
    rd(0, 0, v, d, ds);
    total++; if (ds !== 4'd15) begin bad++; $display("FAIL sat_start_cnt got=%0d exp=15", ds); end
    total++; if (d !== 32'd17) begin bad++; $display("FAIL wide_start_cnt got=%0d exp=17", d); end
    total++; if (overflow_s !== 3'b001) begin bad++; $display("FAIL sat_overflow got=%b exp=001", overflow_s); end
    total++; if (overflow !== 3'b000) begin bad++; $display("FAIL wide_overflow got=%b exp=000", overflow); end
    rd(0, 7, v, d, ds);
    total++; if (ds !== 4'd5) begin bad++; $display("FAIL sat_ovf_state got=%0d exp=5", ds); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    rd(0, 0, v, d, ds);
    total++; if (ds !== 4'd0) begin bad++; $display("FAIL sat_clear_cnt got=%0d exp=0", ds); end
    total++; if (overflow_s !== 3'b000) begin bad++; $display("FAIL sat_clear_ovf got=%b exp=000", overflow_s); end
  endtask

  task automatic test_finish();
    logic v; logic [31:0] d; logic [3:0] ds;
    do_reset();
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
    repeat (2) tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ap_start = i[0] ? 3'b011 : 3'b110;
      ap_ready = 3'b111;
      ap_done  = i[0] ? 3'b111 : 3'b001;
      tick();
    end
    idle();
    total++; if (frozen !== 1'b1) begin bad++; $display("FAIL finish_frozen got=%0b exp=1", frozen); end
    rd(0, 0, v, d, ds);
    total++; if (v !== 1'b1 || d !== 32'd1) begin bad++; $display("FAIL finish_start_cnt v=%0b got=%0d exp=1", v, d); end
    rd(0, 2, v, d, ds);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL finish_busy got=%0d exp=3", d); end
    rd(0, 1, v, d, ds);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL finish_done_cnt got=%0d exp=0", d); end
    rd(0, 7, v, d, ds);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL finish_state got=%0d exp=1", d); end
    rd(1, 0, v, d, ds);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL finish_ch1_start got=%0d exp=0", d); end
    tick();
    total++; if (rd_valid !== 1'b0 || rd_data !== 32'd0) begin bad++; $display("FAIL finish_rd_idle v=%0b got=%0d exp=0", rd_valid, rd_data); end
  endtask

  task automatic test_precedence();
    logic v; logic [31:0] d; logic [3:0] ds;
    do_reset();
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
    tick();
    ap_done[0] = 1'b1; clear = 1'b1;
    tick();
    ap_done[0] = 1'b0; clear = 1'b0;
    rd(0, 1, v, d, ds);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL clear_vs_done got=%0d exp=0", d); end
    rd(0, 7, v, d, ds);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL clear_state got=%0d exp=0", d); end
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
    tick();
    reset = 1'b1; clear = 1'b1; rd_en = 1'b1; rd_ch = 4'd0; rd_sel = 3'd0;
    tick();
    reset = 1'b0; clear = 1'b0; rd_en = 1'b0;
    total++; if (rd_valid !== 1'b0 || rd_data !== 32'd0) begin bad++; $display("FAIL reset_wins_rd v=%0b got=%0d exp=0", rd_valid, rd_data); end
    total++; if (frozen !== 1'b0 || overflow !== 3'b000) begin bad++; $display("FAIL reset_wins_flags got=%0b/%b exp=0/000", frozen, overflow); end
    rd(0, 2, v, d, ds);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_wins_busy got=%0d exp=0", d); end
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
    rd(NUM_CH, 0, v, d, ds);
    total++; if (v !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL bad_channel v=%0b got=%0d exp=1/0", v, d); end
    rd(0, 0, v, d, ds);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL ch0_after_reset got=%0d exp=1", d); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_saturation();
    test_finish();
    test_precedence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
